// File: rtl/mod_counter_if.sv
// mod_counter_if: control inputs and registered status outputs of mod_counter
// pre_tick exists only when COUNTER_PRESCALE_EN is defined.
interface mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             mode_sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] value;
  logic             tc;
  logic             zero;
  logic             sat;
`ifdef COUNTER_PRESCALE_EN
  logic             pre_tick;
  modport master (output en, up, mode_sat, load, load_val, input value, tc, zero, sat, pre_tick);
  modport slave  (input en, up, mode_sat, load, load_val, output value, tc, zero, sat, pre_tick);
`else
  modport master (output en, up, mode_sat, load, load_val, input value, tc, zero, sat);
  modport slave  (input en, up, mode_sat, load, load_val, output value, tc, zero, sat);
`endif
endinterface

// File: rtl/mod_counter.sv
// mod_counter: up/down modulo counter with load, wrap/saturate and registered tc/zero/sat flags
// Define COUNTER_PRESCALE_EN to divide the count enable by PRESCALE (adds pre_tick).
module mod_counter #(
  parameter int     WIDTH     = 8,
  parameter longint MODULUS   = 256,
  parameter int     RESET_VAL = 0,
  parameter int     PRESCALE  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RESET_VAL);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH %0d out of range 1..32", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS %0d out of range 2..2**WIDTH", MODULUS);
  end
  if (RESET_VAL < 0 || longint'(RESET_VAL) >= MODULUS) begin : g_bad_reset
    $error("mod_counter: RESET_VAL %0d must be below MODULUS", RESET_VAL);
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("mod_counter: PRESCALE %0d must be at least 2", PRESCALE);
  end
  logic [WIDTH-1:0] r_value;
  logic             r_tc;
  logic             r_zero;
  logic             r_sat;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;
  logic             w_step;
  logic             w_bound;
  logic             w_wrap;
  logic             w_block;
`ifdef COUNTER_PRESCALE_EN
  localparam int PW = PRESCALE > 2 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  logic [PW-1:0] r_pre;
  logic          r_pre_tick;
  always_ff @(posedge clk)
    if (!reset || bus.load) begin
      r_pre      <= '0;
      r_pre_tick <= 1'b0;
    end else begin
      if (bus.en) r_pre <= (r_pre == PLAST) ? '0 : r_pre + 1'b1;
      r_pre_tick <= w_step;
    end
  assign w_step       = bus.en & (r_pre == PLAST);
  assign bus.pre_tick = r_pre_tick;
`else
  assign w_step = bus.en;
`endif
  // compare in WIDTH+1 bits so a full-range MODULUS cannot overflow the bound
  always_comb begin
    w_bound = bus.up ? (r_value == TOP) : (r_value == '0);
    w_wrap  = w_step & w_bound & ~bus.mode_sat;
    w_block = w_step & w_bound & bus.mode_sat;
    w_next  = (!w_step || w_block) ? r_value
            : w_wrap ? (bus.up ? '0 : TOP)
            : bus.up ? r_value + 1'b1 : r_value - 1'b1;
    w_load  = ({1'b0, bus.load_val} > {1'b0, TOP}) ? TOP : bus.load_val;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      r_value <= RV;
      r_zero  <= (RV == '0);
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
    end else if (bus.load) begin
      r_value <= w_load;
      r_zero  <= (w_load == '0);
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_value <= w_next;
      r_zero  <= (w_next == '0);
      r_tc    <= w_wrap;
      r_sat   <= w_step ? w_block : r_sat;
    end
  assign bus.value = r_value;
  assign bus.tc    = r_tc;
  assign bus.zero  = r_zero;
  assign bus.sat   = r_sat;
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed plan plus random traffic checked against a modular-arithmetic model
module tb_mod_counter;
  localparam int     W  = 8;
  localparam longint M  = 10;
  localparam int     RV = 0;
  localparam int     P  = 4;
  localparam int     MI = int'(M);
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mod_counter_if #(.WIDTH(W)) bus ();
  mod_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(RV), .PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  int n_tests = 0;
  int n_fail  = 0;
  int m_val, m_pre;
  logic m_tc, m_sat, m_pt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // model the edge from the current inputs, then compare every output just after it
  task automatic tick();
    bit step;
    if (!reset) begin
      m_val = RV; m_tc = 0; m_sat = 0; m_pre = 0; m_pt = 0;
    end else if (bus.load) begin
      m_val = (int'(bus.load_val) >= MI) ? MI - 1 : int'(bus.load_val);
      m_tc = 0; m_sat = 0; m_pre = 0; m_pt = 0;
    end else begin
`ifdef COUNTER_PRESCALE_EN
      step = bus.en && (m_pre == P - 1);
      if (bus.en) m_pre = (m_pre + 1) % P;
`else
      step = bus.en;
`endif
      m_pt = step;
      m_tc = 0;
      if (step) begin
        if (bus.up ? (m_val == MI - 1) : (m_val == 0)) begin
          m_sat = bus.mode_sat;
          if (!bus.mode_sat) begin
            m_val = bus.up ? 0 : MI - 1;
            m_tc  = 1;
          end
        end else begin
          m_val = bus.up ? m_val + 1 : m_val - 1;
          m_sat = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("value", bus.value, m_val);
    chk("zero", bus.zero, m_val == 0);
    chk("tc", bus.tc, m_tc);
    chk("sat", bus.sat, m_sat);
`ifdef COUNTER_PRESCALE_EN
    chk("pre_tick", bus.pre_tick, m_pt);
`endif
  endtask

  initial begin
    reset = 0; bus.en = 1; bus.up = 1; bus.mode_sat = 0; bus.load = 1; bus.load_val = 8'd5;
    tick(); tick();
    chk("reset_value", bus.value, 0);
    chk("reset_zero", bus.zero, 1);
    chk("reset_tc", bus.tc, 0);
    reset = 1; bus.load = 0;
    for (int i = 0; i < 10; i++) tick();
`ifndef COUNTER_PRESCALE_EN
    chk("wrap_up_value", bus.value, 0);
    chk("wrap_up_tc", bus.tc, 1);
    chk("wrap_up_zero", bus.zero, 1);
`endif
    bus.up = 0;
    tick();
`ifndef COUNTER_PRESCALE_EN
    chk("wrap_dn_value", bus.value, 9);
    chk("wrap_dn_tc", bus.tc, 1);
`endif
    tick(); tick();
    bus.load = 1; bus.load_val = 8'd8;
    tick();
    bus.load = 0; bus.up = 1; bus.mode_sat = 1;
    tick(); tick(); tick();
`ifndef COUNTER_PRESCALE_EN
    chk("sat_value", bus.value, 9);
    chk("sat_flag", bus.sat, 1);
`endif
    bus.up = 0;
    tick();
    bus.load = 1; bus.load_val = 8'd200; bus.en = 1; bus.up = 1; bus.mode_sat = 0;
    tick();
    chk("clamp_value", bus.value, 9);
    chk("clamp_tc", bus.tc, 0);
    bus.load_val = 8'd3;
    tick();
    chk("load3_value", bus.value, 3);
    bus.load = 0;
    tick(); tick();
    reset = 0; bus.load = 1; bus.load_val = 8'd7;
    tick();
    chk("rst_over_load", bus.value, RV);
    reset = 1; bus.load = 0;
    tick();
    for (int i = 0; i < 13; i++) tick();
    bus.en = 0;
    tick(); tick();
    bus.en = 1;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(31) != 0);
      bus.load     = ($urandom_range(7) == 0);
      bus.en       = ($urandom_range(3) != 0);
      bus.up       = $urandom_range(1) == 1;
      bus.mode_sat = ($urandom_range(3) == 0);
      bus.load_val = W'($urandom_range(255));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
